// File: rtl/pkt_frame_pkg.sv
// rtl/pkt_frame_pkg.sv - shared types and constants for the packet frame tracker
// Contents: per-channel state enum, error code constants, per-channel response struct.
package pkt_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HEAD = 3'd1,
        ST_DATA = 3'd2,
        ST_TAIL = 3'd3,
        ST_DROP = 3'd4
    } state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ORPHAN   = 3'd1;
    localparam logic [2:0] ERR_NESTED   = 3'd2;
    localparam logic [2:0] ERR_OVERLONG = 3'd3;
    localparam logic [2:0] ERR_BAD_CHAN = 3'd4;

    // Response length carries one bit beyond any supported LEN_W (<= 16) so
    // the top can see len+1 overflowing the output width and saturate it.
    localparam int RESP_LEN_W = 17;

    typedef struct packed {
        logic                  done;
        logic                  err;
        logic [2:0]            code;
        logic [RESP_LEN_W-1:0] len;
    } resp_t;

endpackage

// File: rtl/pkt_chan_fsm.sv
// rtl/pkt_chan_fsm.sv - framing state and beat length of a single channel
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   en_i           a beat for this channel is accepted this cycle
//   head_i, tail_i beat framing flags
//   flush_i        synchronous clear to IDLE, len 0
//   resp_o         combinational response for the accepted beat
//   busy_o         channel is inside a packet (HEAD, DATA or DROP)
module pkt_chan_fsm
    import pkt_frame_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAX_LEN = 200
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  en_i,
    input  logic  head_i,
    input  logic  tail_i,
    input  logic  flush_i,
    output resp_t resp_o,
    output logic  busy_o
);

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            len_d   = '0;
        end else if (en_i) begin
            case (state_q)
                ST_IDLE, ST_TAIL: begin
                    if (head_i) begin
                        state_d = tail_i ? ST_TAIL : ST_HEAD;
                        len_d   = LEN_ONE;
                    end
                end
                ST_HEAD, ST_DATA: begin
                    if (head_i) begin
                        // Nested head abandons the open packet and restarts.
                        state_d = tail_i ? ST_TAIL : ST_HEAD;
                        len_d   = LEN_ONE;
                    end else if (tail_i) begin
                        state_d = ST_TAIL;
                    end else if (len_q == MAX_LEN_V) begin
                        // len stays at MAX_LEN so it can never wrap.
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_DATA;
                        len_d   = len_q + LEN_ONE;
                    end
                end
                ST_DROP: begin
                    if (head_i) begin
                        state_d = tail_i ? ST_TAIL : ST_HEAD;
                        len_d   = LEN_ONE;
                    end else if (tail_i) begin
                        state_d = ST_IDLE;
                        len_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    len_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        resp_o      = '0;
        resp_o.code = ERR_NONE;
        if (en_i && !flush_i) begin
            case (state_q)
                ST_IDLE, ST_TAIL: begin
                    if (head_i && tail_i) begin
                        resp_o.done = 1'b1;
                        resp_o.len  = RESP_LEN_W'(1);
                    end else if (!head_i) begin
                        resp_o.err  = 1'b1;
                        resp_o.code = ERR_ORPHAN;
                    end
                end
                ST_HEAD, ST_DATA: begin
                    if (head_i) begin
                        resp_o.err  = 1'b1;
                        resp_o.code = ERR_NESTED;
                        if (tail_i) begin
                            resp_o.done = 1'b1;
                            resp_o.len  = RESP_LEN_W'(1);
                        end
                    end else if (tail_i) begin
                        resp_o.done = 1'b1;
                        resp_o.len  = RESP_LEN_W'(len_q) + RESP_LEN_W'(1);
                    end else if (len_q == MAX_LEN_V) begin
                        resp_o.err  = 1'b1;
                        resp_o.code = ERR_OVERLONG;
                    end
                end
                ST_DROP: begin
                    if (head_i && tail_i) begin
                        resp_o.done = 1'b1;
                        resp_o.len  = RESP_LEN_W'(1);
                    end
                end
                default: resp_o = '0;
            endcase
        end
    end

    assign busy_o = (state_q == ST_HEAD) || (state_q == ST_DATA) || (state_q == ST_DROP);

endmodule

// File: rtl/pkt_frame_tracker.sv
// rtl/pkt_frame_tracker.sv - multi-channel head/data/tail framing tracker
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   valid_i, head_i, tail_i beat and its framing flags
//   chan_i                  channel of the beat
//   flush_i                 synchronous clear of all channel state
//   pkt_done_o/chan/len     registered pulse for a cleanly closed packet
//   err_o/err_code/err_chan registered pulse for a framing error
//   busy_o                  per-channel in-packet flags
//   pkt_count_o/err_count_o saturating event counters
module pkt_frame_tracker
    import pkt_frame_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CH_W    = 2,
    parameter int LEN_W   = 8,
    parameter int MAX_LEN = 200,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              head_i,
    input  logic              tail_i,
    input  logic [CH_W-1:0]   chan_i,
    input  logic              flush_i,
    output logic              pkt_done_o,
    output logic [CH_W-1:0]   pkt_chan_o,
    output logic [LEN_W-1:0]  pkt_len_o,
    output logic              err_o,
    output logic [2:0]        err_code_o,
    output logic [CH_W-1:0]   err_chan_o,
    output logic [NUM_CH-1:0] busy_o,
    output logic [CNT_W-1:0]  pkt_count_o,
    output logic [CNT_W-1:0]  err_count_o
);

    logic [CH_W:0]     chan_ext;
    logic              bad_chan;
    logic [NUM_CH-1:0] en;
    resp_t             resp_all [NUM_CH];
    resp_t             sel;
    logic              len_ovf;

    logic              done_q, done_d;
    logic [CH_W-1:0]   pchan_q, pchan_d;
    logic [LEN_W-1:0]  plen_q, plen_d;
    logic              err_q, err_d;
    logic [2:0]        code_q, code_d;
    logic [CH_W-1:0]   echan_q, echan_d;
    logic [CNT_W-1:0]  pcnt_q, pcnt_d;
    logic [CNT_W-1:0]  ecnt_q, ecnt_d;

    // Extra bit keeps the range test meaningful when NUM_CH == 2**CH_W.
    assign chan_ext = {1'b0, chan_i};
    assign bad_chan = chan_ext >= (CH_W+1)'(NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign en[i] = valid_i && !flush_i && (chan_i == CH_W'(i));

        pkt_chan_fsm #(
            .LEN_W   (LEN_W),
            .MAX_LEN (MAX_LEN)
        ) u_fsm (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (en[i]),
            .head_i  (head_i),
            .tail_i  (tail_i),
            .flush_i (flush_i),
            .resp_o  (resp_all[i]),
            .busy_o  (busy_o[i])
        );
    end

    always_comb begin
        sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (en[k]) sel = resp_all[k];
        end
    end

    // A MAX_LEN+1 beat packet may not fit LEN_W; saturate instead of wrapping.
    assign len_ovf = |sel.len[RESP_LEN_W-1:LEN_W];

    always_comb begin
        done_d  = 1'b0;
        pchan_d = '0;
        plen_d  = '0;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
        echan_d = '0;
        if (valid_i && !flush_i) begin
            if (bad_chan) begin
                err_d   = 1'b1;
                code_d  = ERR_BAD_CHAN;
                echan_d = chan_i;
            end else begin
                if (sel.done) begin
                    done_d  = 1'b1;
                    pchan_d = chan_i;
                    plen_d  = len_ovf ? '1 : sel.len[LEN_W-1:0];
                end
                if (sel.err) begin
                    err_d   = 1'b1;
                    code_d  = sel.code;
                    echan_d = chan_i;
                end
            end
        end
    end

    assign pcnt_d = (done_d && (pcnt_q != '1)) ? pcnt_q + CNT_W'(1) : pcnt_q;
    assign ecnt_d = (err_d  && (ecnt_q != '1)) ? ecnt_q + CNT_W'(1) : ecnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q  <= 1'b0;
            pchan_q <= '0;
            plen_q  <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            echan_q <= '0;
            pcnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            done_q  <= done_d;
            pchan_q <= pchan_d;
            plen_q  <= plen_d;
            err_q   <= err_d;
            code_q  <= code_d;
            echan_q <= echan_d;
            pcnt_q  <= pcnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign pkt_done_o  = done_q;
    assign pkt_chan_o  = pchan_q;
    assign pkt_len_o   = plen_q;
    assign err_o       = err_q;
    assign err_code_o  = code_q;
    assign err_chan_o  = echan_q;
    assign pkt_count_o = pcnt_q;
    assign err_count_o = ecnt_q;

endmodule
